// File: rtl/schmidl_cox_pkg.sv
// Shared types and constants for the Schmidl-Cox preamble inserter:
// FSM states, PRBS7 seed/taps and the I/Q field positions within a sample word.
package schmidl_cox_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HALF1   = 2'd1,
        HALF2   = 2'd2,
        PAYLOAD = 2'd3
    } state_e;

    localparam logic [6:0] PRBS_SEED   = 7'h7F;
    localparam int         PRBS_TAP_HI = 6;
    localparam int         PRBS_TAP_LO = 5;

    localparam int I_MSB = 31;
    localparam int I_LSB = 16;
    localparam int Q_MSB = 15;
    localparam int Q_LSB = 0;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/schmidl_cox_preamble_inserter_if.sv
// AXI-Stream style sample bus (32-bit I/Q word plus last) used to bundle the
// inserter's input and output streams on the bench side.
interface schmidl_cox_preamble_inserter_if;

    // A beat transfers on a rising clk edge where tvalid and tready are both high;
    // the master holds tdata/tlast stable while tvalid is high and tready is low.
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/schmidl_cox_preamble_inserter_prbs7_gen.sv
// PRBS7 LFSR (x^7 + x^6 + 1) producing one BPSK bit per accepted preamble sample.
module prbs7_gen
    import schmidl_cox_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    output logic prbs_bit
);

    logic [6:0] s_q;
    logic [6:0] s_d;

    // Load wins over advance so the final sample of a half reseeds for the next.
    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = PRBS_SEED;
        end else if (advance) begin
            s_d = prbs7_next(s_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= PRBS_SEED;
        end else begin
            s_q <= s_d;
        end
    end

    assign prbs_bit = s_q[PRBS_TAP_HI];

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a two-half Schmidl-Cox BPSK training symbol to every input frame,
// then passes the frame through combinationally.
module schmidl_cox_preamble_inserter
    import schmidl_cox_pkg::*;
#(
    parameter int                 FFT_SIZE = 16,
    parameter logic signed [15:0] AMP      = 16'sd8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        o_preamble,
    output state_e      dbg_state
);

    localparam int                 HALF     = FFT_SIZE / 2;
    localparam int                 CNT_W    = $clog2(HALF);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HALF - 1);
    localparam logic signed [15:0] NEG_AMP  = 16'(-AMP);

    if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_fft_size
        $error("FFT_SIZE must be a power of two and at least 4");
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             prbs_load;
    logic             prbs_adv;
    logic             prbs_bit;
    logic             flush;

    assign flush = reset | clear;

    prbs7_gen u_prbs (
        .clk      (clk),
        .reset    (flush),
        .load     (prbs_load),
        .advance  (prbs_adv),
        .prbs_bit (prbs_bit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prbs_load  = 1'b0;
        prbs_adv   = 1'b0;
        i_tready   = 1'b0;
        o_tdata    = '0;
        o_tlast    = 1'b0;
        o_tvalid   = 1'b0;
        o_preamble = 1'b0;

        case (state_q)
            IDLE: begin
                // Only peek at i_tvalid; the first payload beat stays on the input.
                prbs_load = 1'b1;
                cnt_d     = '0;
                if (i_tvalid) begin
                    state_d = HALF1;
                end
            end
            HALF1, HALF2: begin
                o_tvalid                = 1'b1;
                o_preamble              = 1'b1;
                o_tdata[I_MSB:I_LSB]    = prbs_bit ? NEG_AMP : AMP;
                o_tdata[Q_MSB:Q_LSB]    = 16'h0000;
                if (o_tready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        prbs_load = 1'b1;
                        state_d   = (state_q == HALF1) ? HALF2 : PAYLOAD;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        prbs_adv = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                if (i_tvalid && o_tready && i_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: doc/schmidl_cox_preamble_inserter.md
SCHMIDL_COX_PREAMBLE_INSERTER -- requirements
Module: schmidl_cox_preamble_inserter

Interface
REQ-001 SHALL have parameter FFT_SIZE, 16, preamble length in samples (power of two, >=4; elaboration error otherwise).
REQ-002 SHALL have parameter AMP, 16'sd8192, BPSK amplitude on I.
REQ-003 SHALL have ports: clk input 1, sole clock; reset and clear are synchronous, active-high.
REQ-004 SHALL have reset input 1, synchronous active-high reset.
REQ-005 SHALL have clear input 1, synchronous active-high flush, same effect as reset.
REQ-006 SHALL have i_tdata input 32, payload sample, I in [31:16], Q in [15:0], signed 16-bit each.
REQ-007 SHALL have i_tlast input 1, last payload sample of frame; i_tvalid input 1; i_tready output 1.
REQ-008 SHALL have o_tdata output 32, same format; o_tlast output 1; o_tvalid output 1; o_tready input 1.
REQ-009 SHALL have o_preamble output 1, high while a preamble sample is presented on o_tdata.

Function
REQ-010 SHALL prepend one Schmidl-Cox training symbol of FFT_SIZE samples (two identical halves of HALF = FFT_SIZE/2) before every input frame.
REQ-011 SHALL implement FSM states IDLE, HALF1, HALF2, PAYLOAD.
REQ-012 IDLE: i_tready=0, o_tvalid=0; on i_tvalid=1, go to HALF1 next cycle without consuming the input sample.
REQ-013 HALF1/HALF2: o_tvalid=1, o_tlast=0, o_preamble=1, i_tready=0; sample index advances only on o_tvalid&&o_tready.
REQ-014 HALF1 -> HALF2 on acceptance of sample HALF-1; HALF2 -> PAYLOAD on acceptance of sample HALF-1 of the second half.
REQ-015 PAYLOAD: combinational pass-through, o_tdata=i_tdata, o_tlast=i_tlast, o_tvalid=i_tvalid, i_tready=o_tready, o_preamble=0; zero latency.
REQ-016 PAYLOAD -> IDLE on accepted beat with i_tlast=1; exactly one idle cycle between frames.
REQ-017 Preamble sample k of a half SHALL be o_tdata = {b_k ? -AMP : +AMP, 16'h0000}, b_k = PRBS7 bit k.
REQ-018 PRBS7: 7-bit state s, seed 7'h7F at start of each half; b_k = s[6]; next s = {s[5:0], s[6]^s[5]}.
REQ-019 PRBS state SHALL advance only on accepted preamble beats; stall (o_tready=0) holds o_tdata stable.
REQ-020 -AMP SHALL be computed as two's complement at 16 bits; no saturation needed for AMP > -32768.
REQ-021 Sample counter width SHALL be $clog2(HALF); wraps to 0 at each half boundary.
REQ-022 A frame of a single beat (i_tlast=1 on first beat) SHALL be preamble + one payload beat, then IDLE.

Reset
REQ-023 On reset or clear: state=IDLE, counter=0, PRBS=7'h7F; next cycle o_tvalid=0, i_tready=0, o_tlast=0, o_preamble=0.
REQ-024 Reset/clear mid-preamble or mid-payload SHALL abort the frame; no partial-preamble resumption; the next frame starts a full preamble.
REQ-025 Reset SHALL take precedence over any simultaneous handshake.

Structure
REQ-026 Package schmidl_cox_pkg SHALL hold the FSM state enum, PRBS7 seed and tap constants, sample-field slice constants.
REQ-027 One sub-module prbs7_gen (inputs clk, reset, load, advance; output bit) SHALL hold the LFSR; the FSM, counter and mux stay in the top.
REQ-028 Implementation SHALL be 120-400 lines total; no RAM, no DSP.

Verification
REQ-029 FFT_SIZE=16, o_tready=1, 4-beat frame: 8 preamble beats per half; samples 0-6 = 32'hE000_0000, sample 7 = 32'h2000_0000; half2 == half1; then 4 payload beats unchanged, o_tlast on beat 4.
REQ-030 Random o_tready backpressure (50%) during preamble: output sequence identical to REQ-029; o_tdata stable while stalled.
REQ-031 Back-to-back frames with i_tvalid held high: each frame gets a full 16-sample preamble; exactly one idle cycle between frames.
REQ-032 Assert reset at preamble sample 5: outputs idle next cycle; next frame preamble restarts at 32'hE000_0000.
REQ-033 Single-beat frame 32'h1234_5678 with i_tlast=1: 16 preamble beats, then 32'h1234_5678 with o_tlast=1, then IDLE.
REQ-034 Assert clear during PAYLOAD with i_tvalid=1: i_tready=0 next cycle, no further payload forwarded, o_preamble=0.
